// File: rtl/pl_pkg.sv
// Shared definitions for the elastic pipeline-stage register: state encoding and default widths.
package pl_pkg;

    localparam int unsigned PL_XLEN   = 32;
    localparam int unsigned PL_CTRL_W = 3;

    typedef enum logic [1:0] {
        PL_ST_EMPTY = 2'd0,
        PL_ST_ONE   = 2'd1,
        PL_ST_TWO   = 2'd2
    } pl_state_e;

endpackage

// File: rtl/pl_sat_counter.sv
// Saturating event counter: increments once per cycle with inc=1, sticks at all-ones.
module pl_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pl_stage_reg.sv
// Elastic pipeline-stage register: two-entry skid buffer, registered in_ready, flush-to-bubble.
// Optional stall/bubble statistics counters are built when PL_STAGE_STATS_EN is defined.
module pl_stage_reg
    import pl_pkg::*;
#(
    parameter int unsigned WIDTH  = PL_XLEN,
    parameter int unsigned CTRL_W = PL_CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PL_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("pl_stage_reg: CNT_W must be at least 1");
    end

    pl_state_e         state_d,     state_q;
    logic              in_ready_d,  in_ready_q;
    logic              out_valid_d, out_valid_q;
    logic [WIDTH-1:0]  main_data_d, main_data_q;
    logic [CTRL_W-1:0] main_ctrl_d, main_ctrl_q;
    logic [WIDTH-1:0]  skid_data_d, skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_d, skid_ctrl_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next state; vacated or flushed entries are zeroed so an invalid slot never carries ctrl bits.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (clr) begin
            state_d     = PL_ST_EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                PL_ST_EMPTY: begin
                    if (in_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = PL_ST_ONE;
                    end
                end
                PL_ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = PL_ST_TWO;
                    end else if (out_fire) begin
                        main_data_d = '0;
                        main_ctrl_d = '0;
                        state_d     = PL_ST_EMPTY;
                    end
                end
                PL_ST_TWO: begin
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_data_d = '0;
                        skid_ctrl_d = '0;
                        state_d     = PL_ST_ONE;
                    end
                end
                default: begin
                    state_d     = PL_ST_EMPTY;
                    main_data_d = '0;
                    main_ctrl_d = '0;
                    skid_data_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end

        // Handshake flags are precomputed from the next state so both leave the stage from flops.
        in_ready_d  = (state_d != PL_ST_TWO);
        out_valid_d = (state_d != PL_ST_EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PL_ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;

`ifdef PL_STAGE_STATS_EN
    pl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid_q & ~out_ready),
        .count (stall_cnt)
    );

    pl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~out_valid_q),
        .count (bubble_cnt)
    );
`endif

endmodule
